// File: rtl/dm_pkg.sv
// Shared types for the data-memory arbiter.
// MemOp codes, FSM states and the latched request bundle.
package dm_pkg;

  localparam logic [2:0] MEMOP_W  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_HU = 3'b010;
  localparam logic [2:0] MEMOP_B  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } dm_state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        owner;
  } dm_req_t;

endpackage

// File: rtl/dm_align_chk.sv
// Opcode, alignment and range check for a DM access.
// Ports: memop, addr in; err out (combinational).
module dm_align_chk
  import dm_pkg::*;
#(
  parameter int unsigned DM_BYTES = 16384
) (
  input  logic [2:0]  memop,
  input  logic [31:0] addr,
  output logic        err
);

  logic bad_op;
  logic bad_al;
  logic bad_rng;

  always_comb begin
    bad_op = 1'b0;
    bad_al = 1'b0;
    unique case (memop)
      MEMOP_W:           bad_al = addr[1:0] != 2'b00;
      MEMOP_H, MEMOP_HU: bad_al = addr[0];
      MEMOP_B, MEMOP_BU: bad_al = 1'b0;
      default:           bad_op = 1'b1;
    endcase
  end

  assign bad_rng = addr >= 32'(DM_BYTES);
  assign err     = bad_op | bad_al | bad_rng;

endmodule

// File: rtl/dm_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of the data memory.
// req/gnt accept, ISSUE drives dm_*, RESP pulses done/err with rdata.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned DM_BYTES    = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [2:0]  memop0,
  input  logic [2:0]  memop1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  logic [31:0] pc0,
  input  logic [31:0] pc1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        dm_we,
  output logic [2:0]  dm_memop,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rd
);

  dm_state_t state;
  dm_req_t   lat;
  dm_req_t   nxt;
  logic      last;
  logic      pick;
  logic      idle;
  logic      chk_err;

  assign idle = state == ST_IDLE;

  // pick = 1 selects the DMA; ties go to whoever was not served last
  always_comb begin
    if (req0 && req1)
      pick = ROUND_ROBIN ? ~last : 1'b0;
    else
      pick = req1;
  end

  assign gnt0 = idle & req0 & ~pick;
  assign gnt1 = idle & req1 & pick;

  always_comb begin
    if (pick)
      nxt = '{we1, memop1, addr1, wd1, pc1, 1'b1};
    else
      nxt = '{we0, memop0, addr0, wd0, pc0, 1'b0};
  end

  dm_align_chk #(
    .DM_BYTES (DM_BYTES)
  ) u_chk (
    .memop (lat.memop),
    .addr  (lat.addr),
    .err   (chk_err)
  );

  // the latch doubles as the dm_* bus, so it holds outside ISSUE
  assign dm_memop = lat.memop;
  assign dm_addr  = lat.addr;
  assign dm_wd    = lat.wd;
  assign dm_pc    = lat.pc;
  assign dm_we    = (state == ST_ISSUE) & lat.we & ~chk_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      lat   <= '0;
      last  <= 1'b1;
      rdata <= '0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            lat   <= nxt;
            last  <= pick;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rdata <= chk_err ? 32'h0 : dm_rd;
          done0 <= ~lat.owner;
          done1 <= lat.owner;
          err0  <= ~lat.owner & chk_err;
          err1  <= lat.owner & chk_err;
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural DM model.
// Directed cases plus randomized traffic against a reference model.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int DMB = 16384;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [2:0] memop0 = 0, memop1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
  logic [31:0] pc0 = 0, pc1 = 0;
  logic gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic dm_we;
  logic [2:0] dm_memop;
  logic [31:0] dm_addr, dm_wd, dm_pc, dm_rd;

  logic b_gnt0, b_gnt1, b_done0, b_done1, b_err0, b_err1;
  logic [31:0] b_rdata;
  logic b_dm_we;
  logic [2:0] b_dm_memop;
  logic [31:0] b_dm_addr, b_dm_wd, b_dm_pc;
  logic [31:0] zero32 = 32'h0;

  always #5 clk = ~clk;

  dm_arbiter #(.ROUND_ROBIN(1'b1), .DM_BYTES(DMB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .memop0(memop0), .memop1(memop1),
    .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
    .pc0(pc0), .pc1(pc1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .dm_we(dm_we), .dm_memop(dm_memop), .dm_addr(dm_addr),
    .dm_wd(dm_wd), .dm_pc(dm_pc), .dm_rd(dm_rd)
  );

  dm_arbiter #(.ROUND_ROBIN(1'b0), .DM_BYTES(DMB)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .memop0(memop0), .memop1(memop1),
    .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1),
    .pc0(pc0), .pc1(pc1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1),
    .err0(b_err0), .err1(b_err1), .rdata(b_rdata),
    .dm_we(b_dm_we), .dm_memop(b_dm_memop), .dm_addr(b_dm_addr),
    .dm_wd(b_dm_wd), .dm_pc(b_dm_pc), .dm_rd(zero32)
  );

  // bench data memory: byte array, combinational read, write on edge
  logic [7:0] dmem [DMB] = '{default: 8'h00};
  logic [7:0] rmem [DMB] = '{default: 8'h00};
  int wr_count = 0;
  logic [31:0] a1, a2, a3;
  logic [7:0] rb0, rb1, rb2, rb3;

  assign a1 = dm_addr + 32'd1;
  assign a2 = dm_addr + 32'd2;
  assign a3 = dm_addr + 32'd3;
  assign rb0 = dm_addr < 32'(DMB) ? dmem[dm_addr[13:0]] : 8'hA5;
  assign rb1 = a1 < 32'(DMB) ? dmem[a1[13:0]] : 8'hA5;
  assign rb2 = a2 < 32'(DMB) ? dmem[a2[13:0]] : 8'hA5;
  assign rb3 = a3 < 32'(DMB) ? dmem[a3[13:0]] : 8'hA5;

  always_comb begin
    dm_rd = 32'hBAD0BAD0;
    case (dm_memop)
      3'd0: dm_rd = {rb3, rb2, rb1, rb0};
      3'd1: dm_rd = {{16{rb1[7]}}, rb1, rb0};
      3'd2: dm_rd = {16'h0, rb1, rb0};
      3'd3: dm_rd = {{24{rb0[7]}}, rb0};
      3'd4: dm_rd = {24'h0, rb0};
      default: dm_rd = 32'hBAD0BAD0;
    endcase
  end

  always @(posedge clk) begin
    if (dm_we) begin
      wr_count <= wr_count + 1;
      if (dm_addr < 32'(DMB)) dmem[dm_addr[13:0]] <= dm_wd[7:0];
      if (dm_memop <= 3'd2 && a1 < 32'(DMB)) dmem[a1[13:0]] <= dm_wd[15:8];
      if (dm_memop == 3'd0 && a2 < 32'(DMB)) dmem[a2[13:0]] <= dm_wd[23:16];
      if (dm_memop == 3'd0 && a3 < 32'(DMB)) dmem[a3[13:0]] <= dm_wd[31:24];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: access size, error rule, load/store on rmem
  function automatic int op_size(input logic [2:0] op);
    case (op)
      3'd0: return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op,
                                   input logic [31:0] a);
    int s = op_size(op);
    if (s == 0) return 1'b1;
    return (a >= 32'(DMB)) || ((a & 32'(s - 1)) != 0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [2:0] op,
                                           input logic [31:0] a);
    int s = op_size(op);
    longint v = 0;
    for (int k = s - 1; k >= 0; k--)
      v = (v << 8) | longint'(rmem[int'(a) + k]);
    if ((op == 3'd1 || op == 3'd3) && v >= (longint'(1) << (8 * s - 1)))
      v -= longint'(1) << (8 * s);
    return v[31:0];
  endfunction

  task automatic ref_write(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d);
    int s = op_size(op);
    for (int k = 0; k < s; k++)
      rmem[int'(a) + k] = 8'(d >> (8 * k));
  endtask

  int phase = 0;
  bit last_m = 1'b1;
  bit m_owner, m_we, m_err;
  logic [2:0] m_op;
  logic [31:0] m_addr, m_wd, m_pc, m_rd;
  int exp_writes = 0;
  bit g_seen;
  int obs[$];

  task automatic cyc();
    logic [1:0] eg, egb, ed;
    bit win;
    @(negedge clk);
    eg = 2'b00;
    egb = 2'b00;
    win = 1'b0;
    if (phase == 0 && (req0 || req1)) begin
      win = (req0 && req1) ? ~last_m : req1;
      eg = win ? 2'b10 : 2'b01;
      egb = req0 ? 2'b01 : 2'b10;
    end
    g_seen = gnt0 | gnt1;
    if (g_seen) obs.push_back(int'(gnt1));
    chk("gnt", 32'({gnt1, gnt0}), 32'(eg));
    chk("gnt_fixed", 32'({b_gnt1, b_gnt0}), 32'(egb));
    chk("dm_we", 32'(dm_we), 32'(phase == 1 && m_we && !m_err));
    if (phase != 0) begin
      chk("dm_addr", dm_addr, m_addr);
      chk("dm_wd", dm_wd, m_wd);
      chk("dm_pc", dm_pc, m_pc);
      chk("dm_memop", 32'(dm_memop), 32'(m_op));
    end
    ed = (phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("done", 32'({done1, done0}), 32'(ed));
    chk("err", 32'({err1, err0}), 32'(m_err ? ed : 2'b00));
    if (phase == 2 && (m_err || !m_we))
      chk("rdata", rdata, m_rd);
    if (phase == 0 && (req0 || req1)) begin
      m_owner = win;
      m_we = win ? we1 : we0;
      m_op = win ? memop1 : memop0;
      m_addr = win ? addr1 : addr0;
      m_wd = win ? wd1 : wd0;
      m_pc = win ? pc1 : pc0;
      m_err = ref_err(m_op, m_addr);
      last_m = win;
      phase = 1;
    end else if (phase == 1) begin
      m_rd = m_err ? 32'h0 : ref_read(m_op, m_addr);
      if (m_we && !m_err) begin
        ref_write(m_op, m_addr, m_wd);
        exp_writes++;
      end
      phase = 2;
    end else if (phase == 2) begin
      phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst();
    chk("rst_ctl", 32'({gnt1, gnt0, done1, done0, err1, err0, dm_we}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wd", dm_wd, 0);
    chk("rst_pc", dm_pc, 0);
    chk("rst_memop", 32'(dm_memop), 0);
  endtask

  task automatic txn(input bit who, input bit we, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    if (!who) begin
      req0 = 1; we0 = we; memop0 = op; addr0 = a; wd0 = d;
      pc0 = a + 32'h1000;
    end else begin
      req1 = 1; we1 = we; memop1 = op; addr1 = a; wd1 = d;
      pc1 = a + 32'h2000;
    end
    for (int i = 0; i < 6 && !got; i++) begin
      cyc();
      got = g_seen;
    end
    req0 = 0;
    req1 = 0;
    if (!got) chk("gnt_timeout", 0, 1);
    cyc();
    cyc();
  endtask

  function automatic logic [2:0] rnd_op();
    int r = $urandom_range(0, 12);
    if (r < 10) return 3'(r % 5);
    return 3'(r - 5);
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 19) == 0)
      return 32'h3FF8 + $urandom_range(0, 15);
    return 32'($urandom_range(0, 127));
  endfunction

  initial begin
    bit got;
    int nmis;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_rst();
    end
    @(posedge clk);
    #1 reset = 1'b1;
    phase = 0;
    last_m = 1'b1;

    txn(0, 1, MEMOP_W, 32'h10, 32'hDEADBEEF);
    txn(0, 0, MEMOP_W, 32'h10, 32'h0);
    chk("rd_word", rdata, 32'hDEADBEEF);

    txn(1, 1, MEMOP_W, 32'h12, 32'h12345678);
    chk("word10_kept", {dmem[8'h13], dmem[8'h12], dmem[8'h11], dmem[8'h10]},
        32'hDEADBEEF);

    txn(0, 1, MEMOP_B, 32'h21, 32'h80);
    txn(0, 0, MEMOP_B, 32'h21, 32'h0);
    chk("rd_b", rdata, 32'hFFFFFF80);
    txn(0, 0, MEMOP_BU, 32'h21, 32'h0);
    chk("rd_bu", rdata, 32'h00000080);

    txn(0, 0, 3'b101, 32'h20, 32'h0);
    txn(1, 1, MEMOP_W, 32'h4000, 32'h55AA55AA);
    chk("wr_cnt_dir", 32'(wr_count), 32'(exp_writes));

    obs.delete();
    req0 = 1; we0 = 0; memop0 = MEMOP_W; addr0 = 32'h10;
    req1 = 1; we1 = 0; memop1 = MEMOP_W; addr1 = 32'h20;
    repeat (12) cyc();
    req0 = 0;
    req1 = 0;
    chk("rr_count", 32'(obs.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", i < obs.size() ? 32'(obs[i]) : 32'd2, 32'(i % 2));
    for (int i = 0; i < 3 && phase != 0; i++) cyc();

    req0 = 1; we0 = 1; memop0 = MEMOP_W; addr0 = 32'h30;
    wd0 = 32'hCAFEF00D;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      cyc();
      got = g_seen;
    end
    req0 = 0;
    if (!got) chk("abort_gnt", 0, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(dm_we), 0);
    phase = 0;
    last_m = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_rst();
    @(posedge clk);
    #1 reset = 1'b1;
    cyc();
    cyc();
    chk("abort_mem", {dmem[8'h33], dmem[8'h32], dmem[8'h31], dmem[8'h30]},
        {rmem[8'h33], rmem[8'h32], rmem[8'h31], rmem[8'h30]});
    chk("abort_wr", 32'(wr_count), 32'(exp_writes));
    obs.delete();
    req0 = 1; we0 = 0; req1 = 1; we1 = 0;
    for (int i = 0; i < 4 && obs.size() == 0; i++) cyc();
    req0 = 0;
    req1 = 0;
    chk("rst_tie", obs.size() > 0 ? 32'(obs[0]) : 32'd2, 0);
    cyc();
    cyc();

    for (int n = 0; n < 600; n++) begin
      req0 = $urandom_range(0, 2) != 0;
      req1 = $urandom_range(0, 2) != 0;
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      memop0 = rnd_op();
      memop1 = rnd_op();
      addr0 = rnd_addr();
      addr1 = rnd_addr();
      wd0 = $urandom();
      wd1 = $urandom();
      pc0 = $urandom();
      pc1 = $urandom();
      cyc();
    end
    req0 = 0;
    req1 = 0;
    repeat (4) cyc();

    chk("wr_cnt_all", 32'(wr_count), 32'(exp_writes));
    nmis = 0;
    for (int i = 0; i < DMB; i++)
      if (dmem[i] !== rmem[i]) nmis++;
    chk("mem_image", 32'(nmis), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter: ROUND_ROBIN, 1, 1 = round-robin between requesters, 0 = fixed priority to requester 0 (CPU).
REQ-002 SHALL have parameter: DM_BYTES, 16384, data-memory size in bytes; accesses at or above this address are errors.
REQ-003 SHALL have one clock, clk; reset is asynchronous and active-low, port named reset.
REQ-004 SHALL have ports:
- clk  in  1  clock
- reset  in  1  async active-low reset
- req0/req1  in  1  access request from CPU (0) / DMA (1), held until gnt
- we0/we1  in  1  write enable of request
- memop0/memop1  in  3  MemOp encoding
- addr0/addr1  in  32  byte address
- wd0/wd1  in  32  write data
- pc0/pc1  in  32  PC for trace
- gnt0/gnt1  out  1  one-cycle accept pulse
- done0/done1  out  1  one-cycle completion pulse
- err0/err1  out  1  error flag, valid with done
- rdata  out  32  read data, valid with done
- dm_we  out  1  to DM WE
- dm_memop  out  3  to DM MemOp
- dm_addr  out  32  to DM Addr
- dm_wd  out  32  to DM write data
- dm_pc  out  32  to DM PC
- dm_rd  in  32  combinational DM read data

Function
REQ-005 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE, one transaction in flight.
REQ-006 In IDLE with any req high, SHALL pulse exactly one gnt, latch that requester's we/memop/addr/wd/pc and owner id, and go to ISSUE next cycle.
REQ-007 On simultaneous req0 and req1 with ROUND_ROBIN=1, SHALL grant the requester not granted last; with ROUND_ROBIN=0, SHALL grant requester 0.
REQ-008 In ISSUE, SHALL drive dm_memop/dm_addr/dm_wd/dm_pc from the latch; dm_we = latched we AND NOT error; SHALL capture dm_rd into rdata at the closing edge.
REQ-009 Error SHALL be: memop not in {000,001,010,011,100}; memop 000 with addr[1:0]!=0; memop 001/010 with addr[0]!=0; addr >= DM_BYTES.
REQ-010 Errored accesses SHALL not write DM and SHALL return rdata = 0.
REQ-011 In RESP, SHALL pulse done and err of the owner only, rdata held stable, then go to IDLE.
REQ-012 Outside ISSUE, dm_we SHALL be 0 and other dm_* outputs SHALL hold their last value.
REQ-013 Latency SHALL be: gnt at cycle N, DM write edge at end of N+1, done at N+2; next gnt no earlier than N+3.
REQ-014 req dropped before gnt SHALL have no effect; req held in RESP SHALL be treated as a new request in the next IDLE.
REQ-015 A write of 32'h... SHALL reach DM exactly once per grant.

Reset
REQ-016 On reset low, SHALL go to IDLE immediately: gnt*, done*, err*, dm_we = 0; rdata, dm_* buses = 0; last-grant = requester 1, so requester 0 wins the first tie.
REQ-017 Reset during ISSUE or RESP SHALL abort the transaction, with no done pulse; a write is suppressed if reset is low at the ISSUE edge.

Structure
REQ-018 Shared package dm_pkg SHALL hold MemOp constants (w=000, h=001, hu=010, b=011, bu=100) and FSM state encodings.
REQ-019 Alignment, opcode and range check SHALL be sub-module dm_align_chk (combinational: memop, addr -> err).

Verification
REQ-020 req0 only, we0=1, memop=000, addr=0x10, wd=0xDEADBEEF -> gnt0 at N, dm_we=1 in N+1, done0 at N+2, err0=0; read back gives rdata=0xDEADBEEF.
REQ-021 req0 and req1 held together, ROUND_ROBIN=1 -> grant order 0,1,0,1; ROUND_ROBIN=0 -> all grants to 0 while req0 is held.
REQ-022 we1=1, memop=000, addr=0x12 -> dm_we stays 0, done1 with err1=1, DM word at 0x10 unchanged.
REQ-023 Byte 0x80 at 0x21, then read memop=011 -> rdata=0xFFFFFF80; read memop=100 -> rdata=0x00000080.
REQ-024 addr=0x4000, memop=000 -> err=1, no write; memop=101 -> err=1.
REQ-025 reset asserted during ISSUE of a write -> no done pulse, DM unchanged, FSM in IDLE, first tie after release goes to requester 0.
